// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared constants, IF/ID record type and PC helpers for the
// fetch stage. The address range check helper is only referenced when the
// design is built with FETCH_EXC_EN defined.
package fetch_unit_pkg;

  localparam logic [31:0] PC_RESET = 32'h0000_3000;
  localparam logic [31:0] IMEM_LO  = 32'h0000_3000;
  localparam logic [31:0] IMEM_HI  = 32'h0000_6FFC;
  localparam logic [31:0] NOP      = 32'h0000_0000;
  localparam logic [4:0]  EXC_ADEL = 5'd4;
  localparam logic [4:0]  EXC_NONE = 5'd0;

  // Contents of the IF/ID pipeline register, exception code kept separately
  // so that it can vanish entirely when the exception check is not built.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] pc8;
    logic        valid;
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '{
    instr: NOP,
    pc:    32'h0000_0000,
    pc4:   32'h0000_0000,
    pc8:   32'h0000_0000,
    valid: 1'b0
  };

  // PC arithmetic wraps modulo 2^32 by construction of the 32-bit result.
  function automatic logic [31:0] pc_plus(input logic [31:0] pc, input logic [31:0] inc);
    return pc + inc;
  endfunction

  // A fetch address faults when misaligned or outside instruction memory.
  function automatic logic pc_fault(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (pc < IMEM_LO) || (pc > IMEM_HI);
  endfunction

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// pc_reg: program counter with stall hold and redirect select. Stall has
// priority over a redirect; a redirect seen during a stall is dropped, the
// next-PC unit keeps presenting it until the stall clears.
module pc_reg
  import fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        pc_sel,
  input  logic [31:0] npc,
  output logic [31:0] pc,
  output logic [31:0] pc4
);

  assign pc4 = pc_plus(pc, 32'd4);

  // Hold on stall, otherwise load the redirect target (unmasked) or pc+4.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= PC_RESET;
    end else if (!stall) begin
      pc <= pc_sel ? npc : pc4;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Drives the instruction memory address
// from the PC and captures the returned instruction plus PC, PC+4 and PC+8
// into the IF/ID register. Defining FETCH_EXC_EN adds an address error check
// that replaces a faulting fetch with a nop tagged with the AdEL code.
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] npc,
  input  logic        pc_sel,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] imem_rdata,
  output logic [31:0] imem_addr,
  output logic [31:0] pc_f,
  output logic [31:0] pc4_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc4_d,
  output logic [31:0] pc8_d,
  output logic        valid_d,
  output logic [4:0]  exc_d
);

  ifid_t ifid_q;
  ifid_t capture;

  pc_reg u_pc_reg (
    .clk    (clk),
    .reset  (reset),
    .stall  (stall),
    .pc_sel (pc_sel),
    .npc    (npc),
    .pc     (pc_f),
    .pc4    (pc4_f)
  );

  assign imem_addr = pc_f;

`ifdef FETCH_EXC_EN
  logic       fault;
  logic [4:0] exc_q;

  assign fault = pc_fault(pc_f);
`endif

  // Assemble what the IF/ID register would take on an unstalled cycle.
  always_comb begin
    capture.instr = imem_rdata;
    capture.pc    = pc_f;
    capture.pc4   = pc4_f;
    capture.pc8   = pc_plus(pc_f, 32'd8);
    capture.valid = 1'b1;
`ifdef FETCH_EXC_EN
    if (fault) begin
      capture.instr = NOP;
    end
`endif
  end

  // IF/ID register: flush beats stall, stall holds, otherwise capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ifid_q <= IFID_BUBBLE;
    end else if (flush) begin
      ifid_q <= IFID_BUBBLE;
    end else if (!stall) begin
      ifid_q <= capture;
    end
  end

`ifdef FETCH_EXC_EN
  // Exception code follows the same flush/stall/capture priority as IF/ID.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exc_q <= EXC_NONE;
    end else if (flush) begin
      exc_q <= EXC_NONE;
    end else if (!stall) begin
      exc_q <= fault ? EXC_ADEL : EXC_NONE;
    end
  end

  assign exc_d = exc_q;
`else
  assign exc_d = EXC_NONE;
`endif

  assign instr_d = ifid_q.instr;
  assign pc_d    = ifid_q.pc;
  assign pc4_d   = ifid_q.pc4;
  assign pc8_d   = ifid_q.pc8;
  assign valid_d = ifid_q.valid;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit. Inputs change
// one time unit after a rising edge and outputs are sampled at that point.
module tb_fetch_unit;

`ifdef FETCH_EXC_EN
  localparam bit EXC_ON = 1'b1;
`else
  localparam bit EXC_ON = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [31:0] npc;
  logic        pc_sel;
  logic        stall;
  logic        flush;
  logic [31:0] imem_rdata;
  logic [31:0] imem_addr;
  logic [31:0] pc_f;
  logic [31:0] pc4_f;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc4_d;
  logic [31:0] pc8_d;
  logic        valid_d;
  logic [4:0]  exc_d;

  int tests_run = 0;
  int tests_failed = 0;

  fetch_unit dut (
    .clk        (clk),
    .reset      (reset),
    .npc        (npc),
    .pc_sel     (pc_sel),
    .stall      (stall),
    .flush      (flush),
    .imem_rdata (imem_rdata),
    .imem_addr  (imem_addr),
    .pc_f       (pc_f),
    .pc4_f      (pc4_f),
    .instr_d    (instr_d),
    .pc_d       (pc_d),
    .pc4_d      (pc4_d),
    .pc8_d      (pc8_d),
    .valid_d    (valid_d),
    .exc_d      (exc_d)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Present inputs, then advance one rising edge and settle past it.
  task automatic apply_stimulus(input logic sel, input logic [31:0] target,
                                input logic st, input logic fl,
                                input logic [31:0] rdata);
    pc_sel     = sel;
    npc        = target;
    stall      = st;
    flush      = fl;
    imem_rdata = rdata;
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] e_instr,
                            input logic [31:0] e_pc, input logic e_valid);
    check_output({tag, ".instr_d"}, instr_d, e_instr);
    check_output({tag, ".pc_d"},    pc_d,    e_pc);
    check_output({tag, ".pc4_d"},   pc4_d,   e_valid ? e_pc + 32'd4 : 32'h0);
    check_output({tag, ".pc8_d"},   pc8_d,   e_valid ? e_pc + 32'd8 : 32'h0);
    check_output({tag, ".valid_d"}, {31'b0, valid_d}, {31'b0, e_valid});
  endtask

  initial begin
    reset      = 1'b0;
    npc        = 32'h0;
    pc_sel     = 1'b0;
    stall      = 1'b0;
    flush      = 1'b0;
    imem_rdata = 32'h0;

    // Reset asserted between edges must act immediately.
    #2 reset = 1'b1;
    #1;
    check_output("rst.pc_f", pc_f, 32'h0000_3000);
    check_output("rst.imem_addr", imem_addr, 32'h0000_3000);
    check_ifid("rst", 32'h0, 32'h0, 1'b0);
    check_output("rst.exc_d", {27'b0, exc_d}, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;

    // Three free-running fetches from 0x3000.
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h2408_0001);
    check_ifid("run0", 32'h2408_0001, 32'h0000_3000, 1'b1);
    check_output("run0.pc_f", pc_f, 32'h0000_3004);
    check_output("run0.pc4_f", pc4_f, 32'h0000_3008);
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h2409_0002);
    check_ifid("run1", 32'h2409_0002, 32'h0000_3004, 1'b1);
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h240A_0003);
    check_ifid("run2", 32'h240A_0003, 32'h0000_3008, 1'b1);
    check_output("run2.pc_f", pc_f, 32'h0000_300C);

    // Redirect coinciding with stall is dropped; applies once unstalled.
    apply_stimulus(1'b1, 32'h0000_3100, 1'b1, 1'b0, 32'h1111_1111);
    check_output("redir_stall.pc_f", pc_f, 32'h0000_300C);
    check_ifid("redir_stall", 32'h240A_0003, 32'h0000_3008, 1'b1);
    apply_stimulus(1'b1, 32'h0000_3100, 1'b0, 1'b0, 32'h1111_1111);
    check_output("redir.pc_f", pc_f, 32'h0000_3100);
    check_ifid("redir", 32'h1111_1111, 32'h0000_300C, 1'b1);

    // Redirect to 0x3008 then stall there for two cycles.
    apply_stimulus(1'b1, 32'h0000_3008, 1'b0, 1'b0, 32'h2222_2222);
    check_output("to3008.pc_f", pc_f, 32'h0000_3008);
    check_ifid("to3008", 32'h2222_2222, 32'h0000_3100, 1'b1);
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h3333_3333);
    check_output("stall1.pc_f", pc_f, 32'h0000_3008);
    check_ifid("stall1", 32'h2222_2222, 32'h0000_3100, 1'b1);
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h3333_3333);
    check_output("stall2.pc_f", pc_f, 32'h0000_3008);
    check_ifid("stall2", 32'h2222_2222, 32'h0000_3100, 1'b1);

    // Flush with stall: bubble while PC holds.
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h3333_3333);
    check_output("flush_stall.pc_f", pc_f, 32'h0000_3008);
    check_ifid("flush_stall", 32'h0, 32'h0, 1'b0);

    // Resume, then a flush alone: bubble while PC advances.
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h4444_4444);
    check_ifid("resume", 32'h4444_4444, 32'h0000_3008, 1'b1);
    check_output("resume.pc_f", pc_f, 32'h0000_300C);
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h5555_5555);
    check_ifid("flush", 32'h0, 32'h0, 1'b0);
    check_output("flush.pc_f", pc_f, 32'h0000_3010);

    // Misaligned redirect target is loaded unmodified.
    apply_stimulus(1'b1, 32'h0000_3002, 1'b0, 1'b0, 32'h5555_5555);
    check_output("mis.pc_f", pc_f, 32'h0000_3002);
    check_output("mis.exc_prev", {27'b0, exc_d}, 32'h0);
    apply_stimulus(1'b1, 32'h0000_7000, 1'b0, 1'b0, 32'h6666_6666);
    check_ifid("mis_cap", EXC_ON ? 32'h0 : 32'h6666_6666, 32'h0000_3002, 1'b1);
    check_output("mis_cap.exc_d", {27'b0, exc_d}, EXC_ON ? 32'd4 : 32'd0);
    check_output("hi.pc_f", pc_f, 32'h0000_7000);
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h7777_7777);
    check_ifid("hi_cap", EXC_ON ? 32'h0 : 32'h7777_7777, 32'h0000_7000, 1'b1);
    check_output("hi_cap.exc_d", {27'b0, exc_d}, EXC_ON ? 32'd4 : 32'd0);

    // Wraparound at the top of the address space.
    apply_stimulus(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h8888_8888);
    check_output("wrap.pc_f", pc_f, 32'hFFFF_FFFC);
    check_output("wrap.pc4_f", pc4_f, 32'h0000_0000);
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h8888_8888);
    check_output("wrap_cap.pc_d", pc_d, 32'hFFFF_FFFC);
    check_output("wrap_cap.pc4_d", pc4_d, 32'h0000_0000);
    check_output("wrap_cap.pc8_d", pc8_d, 32'h0000_0004);
    check_output("wrap_cap.pc_f", pc_f, 32'h0000_0000);

    // Mid-cycle reset during stall and redirect overrides both.
    pc_sel = 1'b1;
    npc    = 32'h0000_4000;
    stall  = 1'b1;
    #2 reset = 1'b1;
    #1;
    check_output("rst2.pc_f", pc_f, 32'h0000_3000);
    check_ifid("rst2", 32'h0, 32'h0, 1'b0);
    check_output("rst2.exc_d", {27'b0, exc_d}, 32'h0);
    #1 reset = 1'b0;

    // First fetch after release comes from 0x3000.
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h9999_9999);
    check_ifid("post_rst", 32'h9999_9999, 32'h0000_3000, 1'b1);
    check_output("post_rst.pc_f", pc_f, 32'h0000_3004);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: npc  input  32  redirect target computed by the next-PC unit.
REQ-004 SHALL have port: pc_sel  input  1  1 = load npc, 0 = load pc_f+4.
REQ-005 SHALL have port: stall  input  1  hazard stall; hold PC and IF/ID.
REQ-006 SHALL have port: flush  input  1  replace IF/ID contents with a bubble.
REQ-007 SHALL have port: imem_rdata  input  32  combinational instruction-memory read data.
REQ-008 SHALL have ports: imem_addr and pc_f  output  32  current fetch PC.
REQ-009 SHALL have port: pc4_f  output  32  pc_f+4, combinational.
REQ-010 SHALL have ports: instr_d, pc_d, pc4_d, pc8_d  output  32 each  IF/ID register contents.
REQ-011 SHALL have ports: valid_d  output  1; exc_d  output  5  fetch exception code.

Function
REQ-012 SHALL drive imem_addr = pc_f combinationally; instruction appears on instr_d exactly one cycle after its PC is on pc_f.
REQ-013 SHALL compute pc4_f, pc4_d and pc8_d modulo 2^32 (0xFFFF_FFFC+4 = 0x0000_0000).
REQ-014 PC next value SHALL follow priority: stall -> hold; else pc_sel=1 -> npc; else pc_f+4.
REQ-015 With stall=1 and pc_sel=1 in the same cycle, stall SHALL win; the redirect is not latched, and the next-PC unit re-presents it.
REQ-016 IF/ID SHALL follow priority: flush -> bubble; else stall -> hold; else capture {imem_rdata, pc_f, pc_f+4, pc_f+8, valid=1, exc}.
REQ-017 A bubble SHALL be instr_d=0 (nop), pc_d/pc4_d/pc8_d=0, valid_d=0, exc_d=0.
REQ-018 With flush=1 and stall=1 together, IF/ID SHALL become a bubble while the PC holds.
REQ-019 npc SHALL be loaded unmodified; bits [1:0] are not masked.

Reset
REQ-020 On reset assertion, pc_f SHALL become 0x0000_3000 immediately, without waiting for clk.
REQ-021 On reset assertion, all IF/ID outputs SHALL immediately take bubble values (REQ-017).
REQ-022 Reset asserted during a stall or redirect SHALL override both.
REQ-023 The first fetch after reset release SHALL be from 0x0000_3000.

Configuration
REQ-024 Macro FETCH_EXC_EN SHALL, when defined, check pc_f at capture: if pc_f[1:0]!=0 or pc_f outside [0x0000_3000, 0x0000_6FFC], capture exc_d=5'd4 (AdEL), instr_d=0, valid_d=1, and PC fields as normal.
REQ-025 With FETCH_EXC_EN undefined, exc_d SHALL be constant 0 and no range check logic SHALL exist.

Structure
REQ-026 The shared package SHALL hold: PC_RESET=32'h0000_3000, IMEM_LO=32'h0000_3000, IMEM_HI=32'h0000_6FFC, NOP=32'h0, EXC_ADEL=5'd4, EXC_NONE=5'd0.
REQ-027 The PC register with its hold and select logic SHALL be one sub-module, pc_reg; IF/ID and the exception check stay in fetch_unit.

Verification
REQ-028 Reset pulse mid-cycle -> pc_f=0x3000 before the next edge; instr_d=0, valid_d=0.
REQ-029 Three free-running cycles with imem returning 0x2408_0001, 0x2409_0002, 0x240A_0003 -> instr_d matches in order one cycle late; pc_d = 0x3000, 0x3004, 0x3008; pc8_d = pc_d+8.
REQ-030 pc_sel=1, npc=0x0000_3100 -> next pc_f=0x3100; with stall=1 in the same cycle -> pc_f unchanged, and the redirect takes effect on the first unstalled cycle.
REQ-031 stall=1 for 2 cycles at pc_f=0x3008 -> pc_f and all IF/ID outputs frozen; flush=1 together with stall=1 -> valid_d=0, instr_d=0, pc_f held.
REQ-032 With FETCH_EXC_EN defined: npc=0x0000_3002 -> next capture has exc_d=4, instr_d=0, valid_d=1; npc=0x0000_7000 -> exc_d=4. Without the macro: exc_d=0 in both cases.
REQ-033 Force pc_f=0xFFFF_FFFC via npc, without FETCH_EXC_EN -> pc4_f=0x0, and the next pc_f=0x0.
